alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU: next generation of the 16-bit combinational ALU. Adds a
//  persistent flag register (ZCFNL), carry-in for ADDC/ADDCU, an iterative barrel-free
//  shifter and a shift-add multiplier, behind a start/busy/done handshake. Sits between
//  the register file and the writeback mux of the datapath; the controller issues one op at a time.
// PARAMETERS
//  WIDTH   16  operand/result width (>=4)
//  MUL_EN  1   1 = MUL implemented; 0 = MUL decodes as NOP
// PORTS
//  clk     in   1      rising-edge clock
//  reset   in   1      asynchronous, active-high reset
//  start   in   1      op request; accepted only when busy==0
//  op      in   4      opcode (encoding below)
//  a       in   WIDTH  operand A (dest/left), sampled on accept
//  b       in   WIDTH  operand B (source / signed shift amount), sampled on accept
//  result  out  WIDTH  registered result; held until the next completing op
//  flags   out  5      registered flags: [4]Z [3]C [2]F(overflow) [1]N [0]L
//  busy    out  1      high from the cycle after accept until done
//  done    out  1      one-cycle pulse when result/flags update
// BEHAVIOUR
//  Opcodes: 0000 NOP, 0001 AND, 0010 OR, 0011 XOR, 0100 NOT(A), 0101 ADD, 0110 ADDU, 0111 ADDC,
//   1000 ADDCU, 1001 SUB(A-B), 1011 CMP, 1111 CMPU, 1100 LSH, 1101 MUL; 1010/1110 behave as NOP.
//  Reset: result=0, flags=0, busy=0, done=0, FSM=IDLE; any op in flight is discarded.
//  FSM: IDLE -start-> EXEC (1-cycle ops) | SHIFT | MUL; EXEC/SHIFT/MUL -> IDLE with done=1.
//  Latency: single-cycle ops: done in cycle after accept (1 clk). LSH: n=min(|b|,WIDTH);
//   done n+1 clks after accept (n=0 -> 1 clk). MUL: done WIDTH+1 clks after accept.
//  start while busy=1 is ignored (not queued). start in the same cycle done pulses is
//   accepted (busy low then); back-to-back 1-cycle ops give done every cycle.
//  Arithmetic (mod 2^WIDTH): ADDC/ADDCU add flags[3] as carry-in; SUB = A + ~B + 1.
//  Flags (written only at done; NOP/illegal leave flags and result unchanged):
//   AND/OR/XOR/NOT: Z=(res==0), C=F=N=L=0.
//   ADD/ADDC/SUB: Z, C=carry-out (SUB: C=borrow, i.e. A<B unsigned), F=signed overflow,
//    N=res[WIDTH-1], L=0.  ADDU/ADDCU: Z, C=carry-out, F=N=L=0.
//   CMP/CMPU: result unchanged; Z=(A==B), N=(signed A<B), L=(unsigned A<B), C=F=0.
//   LSH: b[WIDTH-1]=0 -> left by |b|, else logical right by |b|; one bit per clk;
//    |b|>=WIDTH -> result 0 after WIDTH steps. Z=(res==0), C=last bit shifted out (0 if n=0),
//    F=N=L=0.
//   MUL: unsigned shift-add, result=low WIDTH bits; Z=(res==0), C=(high half !=0), F=N=L=0.
//  b = most-negative value in LSH: magnitude saturates to WIDTH (no wrap).
//  reset asserted mid SHIFT/MUL: no done pulse, outputs to reset values immediately.
// STRUCTURE
//  alu_pkg: opcode localparams, flag bit indices (FLAG_Z..FLAG_L), FSM state encoding.
//  Sub-module alu_comb: combinational single-cycle ops + flag generation (WIDTH param);
//   alu_mc holds FSM, operand/shift/multiply registers and the flag register.
// TESTING  (WIDTH=16 unless stated)
//  ADD a=7FFF b=0001 -> done after 1 clk, result=8000, flags=00110 (F,N set).
//  ADDU a=FFFF b=0001 then ADDC a=0000 b=0000 -> 0000 flags 11000, then result 0001 (carry-in used).
//  LSH a=0001 b=0004 -> busy 4 clks, done 5 clks after accept, result=0010; b=FFFF(-1) a=8001 -> 4000, C=1.
//  MUL a=0100 b=0100 -> done after 17 clks, result=0000, flags Z=1 C=1; start during busy ignored.
//  CMP a=FFFE b=0001 -> result unchanged, N=1 L=0 Z=0; CMPU same operands -> L=0 N=0; equal -> Z=1.
//  reset pulse at clk 5 of a MUL -> result=0 flags=0 busy=0, no done; next AND accepted normally.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// ---------------------------------------------------------------------------
// alu_mc_pkg
// Shared definitions for the multi-cycle ALU: opcode encodings, flag bit
// positions inside the 5-bit flag register (Z C F N L), the FSM state type
// and a small helper that builds the flag word for ops that only report
// zero and carry.
// ---------------------------------------------------------------------------
package alu_mc_pkg;

    // Opcode encodings; 4'b1010 and 4'b1110 are unused and behave as NOP
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOT   = 4'b0100;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_ADDU  = 4'b0110;
    localparam logic [3:0] OP_ADDC  = 4'b0111;
    localparam logic [3:0] OP_ADDCU = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_LSH   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1101;
    localparam logic [3:0] OP_CMPU  = 4'b1111;

    // Bit positions inside the flag register
    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_L = 0;

    // IDLE waits for work, EXEC marks the done cycle of a single-cycle op,
    // SHIFT and MUL iterate one bit per clock
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_MUL
    } aluState_t;

    // Flag word for shift and multiply: only Z and C carry information
    function automatic logic [4:0] makeZcFlags(input logic zero, input logic carry);
        logic [4:0] flagWord;
        flagWord         = '0;
        flagWord[FLAG_Z] = zero;
        flagWord[FLAG_C] = carry;
        return flagWord;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// ---------------------------------------------------------------------------
// alu_mc_if
// Handshake and data bus between the controller (master) and the ALU (slave).
//   start  : op request, taken only while busy is low
//   op     : 4-bit opcode
//   a, b   : operands, sampled on accept
//   result : registered result, held until the next completing op
//   flags  : registered flags {Z, C, F, N, L}
//   busy   : high while a multi-cycle op iterates
//   done   : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    import alu_mc_pkg::*;

    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  result, flags, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, flags, busy, done
    );

endinterface

// File: rtl/alu_mc_comb.sv
// ---------------------------------------------------------------------------
// alu_comb
// Purely combinational part of the ALU: evaluates every single-cycle op and
// its flags from the current operands. It also handles LSH by a zero amount,
// which is just a pass-through of A. MUL is not known here and decodes to
// "write nothing", exactly like NOP and the unused encodings.
// Ports:
//   i_op, i_a, i_b   opcode and operands
//   i_carryIn        current C flag, used by ADDC/ADDCU
//   o_result         candidate result
//   o_flags          candidate flags {Z, C, F, N, L}
//   o_writeResult    op updates the result register
//   o_writeFlags     op updates the flag register
// ---------------------------------------------------------------------------
module alu_comb
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carryIn,
    output logic [WIDTH-1:0] o_result,
    output logic [4:0]       o_flags,
    output logic             o_writeResult,
    output logic             o_writeFlags
);

    logic             w_isSub;
    logic [WIDTH-1:0] w_bOperand;
    logic             w_carryIn;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_sumRes;
    logic             w_carryOut;
    logic             w_overflow;
    logic             w_signedLess;
    logic             w_unsignedLess;

    // One shared adder serves ADD/ADDU/ADDC/ADDCU and SUB. Subtraction is
    // A + ~B + 1, so the inverted operand and the forced carry-in turn it
    // into the same addition; overflow is judged on the operand actually added.
    always_comb begin
        w_isSub    = (i_op == OP_SUB);
        w_bOperand = w_isSub ? ~i_b : i_b;
        if ((i_op == OP_ADDC) || (i_op == OP_ADDCU)) begin
            w_carryIn = i_carryIn;
        end else begin
            w_carryIn = w_isSub;
        end
        w_sum          = {1'b0, i_a} + {1'b0, w_bOperand} + {{WIDTH{1'b0}}, w_carryIn};
        w_sumRes       = w_sum[WIDTH-1:0];
        w_carryOut     = w_sum[WIDTH];
        w_overflow     = (i_a[WIDTH-1] == w_bOperand[WIDTH-1]) &&
                         (w_sumRes[WIDTH-1] != i_a[WIDTH-1]);
        w_signedLess   = $signed(i_a) < $signed(i_b);
        w_unsignedLess = i_a < i_b;
    end

    // Opcode decode. Every op that writes a result also reports Z from that
    // result, so Z is filled in once after the case; compares leave the
    // result alone and set Z from operand equality instead. CMP reports the
    // signed ordering in N, CMPU the unsigned ordering in L.
    always_comb begin
        o_result      = '0;
        o_flags       = '0;
        o_writeResult = 1'b0;
        o_writeFlags  = 1'b0;
        case (i_op)
            OP_AND: begin
                o_result      = i_a & i_b;
                o_writeResult = 1'b1;
                o_writeFlags  = 1'b1;
            end
            OP_OR: begin
                o_result      = i_a | i_b;
                o_writeResult = 1'b1;
                o_writeFlags  = 1'b1;
            end
            OP_XOR: begin
                o_result      = i_a ^ i_b;
                o_writeResult = 1'b1;
                o_writeFlags  = 1'b1;
            end
            OP_NOT: begin
                o_result      = ~i_a;
                o_writeResult = 1'b1;
                o_writeFlags  = 1'b1;
            end
            OP_ADD, OP_ADDC, OP_SUB: begin
                o_result        = w_sumRes;
                o_flags[FLAG_C] = w_isSub ? ~w_carryOut : w_carryOut;
                o_flags[FLAG_F] = w_overflow;
                o_flags[FLAG_N] = w_sumRes[WIDTH-1];
                o_writeResult   = 1'b1;
                o_writeFlags    = 1'b1;
            end
            OP_ADDU, OP_ADDCU: begin
                o_result        = w_sumRes;
                o_flags[FLAG_C] = w_carryOut;
                o_writeResult   = 1'b1;
                o_writeFlags    = 1'b1;
            end
            OP_CMP: begin
                o_flags[FLAG_Z] = (i_a == i_b);
                o_flags[FLAG_N] = w_signedLess;
                o_writeFlags    = 1'b1;
            end
            OP_CMPU: begin
                o_flags[FLAG_Z] = (i_a == i_b);
                o_flags[FLAG_L] = w_unsignedLess;
                o_writeFlags    = 1'b1;
            end
            OP_LSH: begin
                o_result      = i_a;
                o_writeResult = 1'b1;
                o_writeFlags  = 1'b1;
            end
            default: begin
                o_writeResult = 1'b0;
            end
        endcase
        if (o_writeResult) begin
            o_flags[FLAG_Z] = (o_result == '0);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU with a persistent flag register. Single-cycle ops are
// evaluated by alu_comb and complete with done in the cycle right after
// accept. LSH walks one bit per clock (n = min(|b|, WIDTH) steps) and MUL is
// a WIDTH-step shift-add, both keeping busy high while iterating.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, discards any op in flight
//   bus    alu_mc_if slave: start/op/a/b in, result/flags/busy/done out
// ---------------------------------------------------------------------------
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input logic     clk,
    input logic     reset,
    alu_mc_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    aluState_t          r_state;
    logic [WIDTH-1:0]   r_result;
    logic [4:0]         r_flags;
    logic               r_busy;
    logic               r_done;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_shiftReg;
    logic               r_shiftLeft;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH-1:0]   w_combResult;
    logic [4:0]         w_combFlags;
    logic               w_combWriteResult;
    logic               w_combWriteFlags;
    logic               w_isShiftOp;
    logic               w_isMulOp;
    logic [WIDTH-1:0]   w_shiftMag;
    logic [CW-1:0]      w_shiftCount;
    logic [WIDTH-1:0]   w_shiftNext;
    logic               w_shiftOut;
    logic [2*WIDTH-1:0] w_accNext;

    alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .i_op         (bus.op),
        .i_a          (bus.a),
        .i_b          (bus.b),
        .i_carryIn    (r_flags[FLAG_C]),
        .o_result     (w_combResult),
        .o_flags      (w_combFlags),
        .o_writeResult(w_combWriteResult),
        .o_writeFlags (w_combWriteFlags)
    );

    // Decode of the incoming request. The shift amount is the magnitude of
    // the signed b, clamped to WIDTH; the most-negative b negates to itself,
    // which read unsigned is still >= WIDTH, so it clamps instead of wrapping.
    always_comb begin
        w_isShiftOp  = (bus.op == OP_LSH);
        w_isMulOp    = MUL_EN && (bus.op == OP_MUL);
        w_shiftMag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
        w_shiftCount = (w_shiftMag >= WIDTH'(WIDTH)) ? CW'(WIDTH) : CW'(w_shiftMag);
    end

    // One iteration step of each multi-cycle unit. The shifter reports the
    // bit falling off the end so the final step can latch it as C; the
    // multiplier adds the shifted multiplicand when the current multiplier
    // bit is set.
    always_comb begin
        w_shiftNext = r_shiftLeft ? {r_shiftReg[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shiftReg[WIDTH-1:1]};
        w_shiftOut  = r_shiftLeft ? r_shiftReg[WIDTH-1] : r_shiftReg[0];
        w_accNext   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    end

    // Controller FSM with registered outputs. IDLE and EXEC both accept a
    // new request because busy is low in both; that is what lets
    // back-to-back single-cycle ops produce done every cycle. SHIFT and MUL
    // count down and write result, flags and done on their last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_result    <= '0;
            r_flags     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_shiftReg  <= '0;
            r_shiftLeft <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_EXEC: begin
                    r_state <= ST_IDLE;
                    if (bus.start) begin
                        if (w_isShiftOp && (w_shiftCount != '0)) begin
                            r_state     <= ST_SHIFT;
                            r_busy      <= 1'b1;
                            r_count     <= w_shiftCount;
                            r_shiftReg  <= bus.a;
                            r_shiftLeft <= ~bus.b[WIDTH-1];
                        end else if (w_isMulOp) begin
                            r_state  <= ST_MUL;
                            r_busy   <= 1'b1;
                            r_count  <= CW'(WIDTH);
                            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                            r_mplier <= bus.b;
                            r_acc    <= '0;
                        end else begin
                            r_state <= ST_EXEC;
                            r_done  <= 1'b1;
                            if (w_combWriteResult) begin
                                r_result <= w_combResult;
                            end
                            if (w_combWriteFlags) begin
                                r_flags <= w_combFlags;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shiftReg <= w_shiftNext;
                    r_count    <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_shiftNext;
                        r_flags  <= makeZcFlags(w_shiftNext == '0, w_shiftOut);
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_accNext[WIDTH-1:0];
                        r_flags  <= makeZcFlags(w_accNext[WIDTH-1:0] == '0,
                                                |w_accNext[2*WIDTH-1:WIDTH]);
                    end
                end
            endcase
        end
    end

    // Everything visible on the bus comes straight from registers
    assign bus.result = r_result;
    assign bus.flags  = r_flags;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
